// File: rtl/noc_inject_arbiter.sv
// Packet-atomic round-robin arbiter that shares the router injection port among NUM_REQ
// AXI-stream sources, with a 2-entry output skid buffer and max-packet-length enforcement.
module noc_inject_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int TDATA_WIDTH   = 32,
    parameter int TID_WIDTH     = 2,
    parameter int TDEST_WIDTH   = 4,
    parameter int MAX_PKT_BEATS = 16,
    parameter int REQ_IDX_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                               clk_noc,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 s_tvalid,
    output logic [NUM_REQ-1:0]                 s_tready,
    input  logic [NUM_REQ*TDATA_WIDTH-1:0]     s_tdata,
    input  logic [NUM_REQ-1:0]                 s_tlast,
    input  logic [NUM_REQ*TID_WIDTH-1:0]       s_tid,
    input  logic [NUM_REQ*TDEST_WIDTH-1:0]     s_tdest,
    output logic                               m_tvalid,
    input  logic                               m_tready,
    output logic [TDATA_WIDTH-1:0]             m_tdata,
    output logic                               m_tlast,
    output logic [TID_WIDTH-1:0]               m_tid,
    output logic [TDEST_WIDTH-1:0]             m_tdest,
    output logic                               grant_valid,
    output logic [REQ_IDX_WIDTH-1:0]           grant_idx,
    output logic                               err_overlen,
    input  logic                               err_clear
);

    localparam int CNT_WIDTH = $clog2(MAX_PKT_BEATS + 1);
    localparam int PAY_WIDTH = 1 + TID_WIDTH + TDEST_WIDTH + TDATA_WIDTH;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t                   state, state_next;
    logic [REQ_IDX_WIDTH-1:0] rr_ptr, rr_ptr_next;
    logic [REQ_IDX_WIDTH-1:0] grant_idx_next;
    logic [REQ_IDX_WIDTH-1:0] winner;
    logic                     win_found;
    logic [CNT_WIDTH-1:0]     beat_cnt, beat_cnt_next;
    logic                     push, pop, buf_full, forced_last;
    logic [PAY_WIDTH-1:0]     in_beat, head_q, tail_q;
    logic [1:0]               count;

    // Round-robin search starting just after the last winner.
    always_comb begin
        winner    = '0;
        win_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!win_found && s_tvalid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                win_found = 1'b1;
                winner    = REQ_IDX_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_next     = state;
        rr_ptr_next    = rr_ptr;
        grant_idx_next = grant_idx;
        beat_cnt_next  = beat_cnt;
        s_tready       = '0;
        push           = 1'b0;
        forced_last    = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    grant_idx_next = winner;
                    rr_ptr_next    = winner;
                    beat_cnt_next  = '0;
                    state_next     = LOCKED;
                end
            end
            LOCKED: begin
                s_tready[grant_idx] = ~buf_full;
                push                = s_tvalid[grant_idx] & ~buf_full;
                if (push) begin
                    beat_cnt_next = beat_cnt + CNT_WIDTH'(1);
                    forced_last   = ~s_tlast[grant_idx] &&
                                    (beat_cnt == CNT_WIDTH'(MAX_PKT_BEATS - 1));
                    if (s_tlast[grant_idx] || forced_last) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= REQ_IDX_WIDTH'(NUM_REQ - 1);
            grant_idx <= '0;
            beat_cnt  <= '0;
        end else begin
            state     <= state_next;
            rr_ptr    <= rr_ptr_next;
            grant_idx <= grant_idx_next;
            beat_cnt  <= beat_cnt_next;
        end
    end

    assign in_beat = {s_tlast[grant_idx] | forced_last,
                      s_tid[int'(grant_idx)*TID_WIDTH +: TID_WIDTH],
                      s_tdest[int'(grant_idx)*TDEST_WIDTH +: TDEST_WIDTH],
                      s_tdata[int'(grant_idx)*TDATA_WIDTH +: TDATA_WIDTH]};

    assign buf_full = (count == 2'd2);
    assign m_tvalid = (count != 2'd0);
    assign pop      = m_tvalid & m_tready;

    // Head register drives the outputs directly; tail only holds the second beat.
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            count  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head_q <= in_beat;
                    else               tail_q <= in_beat;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head_q <= in_beat;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= in_beat;
                    end
                end
                default: ;
            endcase
        end
    end

    assign {m_tlast, m_tid, m_tdest, m_tdata} = head_q;
    assign grant_valid = (state == LOCKED);

    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            err_overlen <= 1'b0;
        end else if (forced_last) begin
            err_overlen <= 1'b1;
        end else if (err_clear) begin
            err_overlen <= 1'b0;
        end
    end

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Randomized and directed bench for noc_inject_arbiter, checked cycle by cycle against a
// queue-based reference model of the arbitration, length limit and skid buffer.
module tb_noc_inject_arbiter;

    localparam int NUM_REQ       = 4;
    localparam int TDATA_WIDTH   = 32;
    localparam int TID_WIDTH     = 2;
    localparam int TDEST_WIDTH   = 4;
    localparam int MAX_PKT_BEATS = 16;
    localparam int REQ_IDX_WIDTH = 2;

    typedef struct packed {
        logic [TDATA_WIDTH-1:0] data;
        logic                   last;
        logic [TID_WIDTH-1:0]   tid;
        logic [TDEST_WIDTH-1:0] tdest;
    } beat_t;

    logic                           clk_noc = 1'b0;
    logic                           rst_n;
    logic [NUM_REQ-1:0]             s_tvalid;
    logic [NUM_REQ-1:0]             s_tready;
    logic [NUM_REQ*TDATA_WIDTH-1:0] s_tdata;
    logic [NUM_REQ-1:0]             s_tlast;
    logic [NUM_REQ*TID_WIDTH-1:0]   s_tid;
    logic [NUM_REQ*TDEST_WIDTH-1:0] s_tdest;
    logic                           m_tvalid;
    logic                           m_tready;
    logic [TDATA_WIDTH-1:0]         m_tdata;
    logic                           m_tlast;
    logic [TID_WIDTH-1:0]           m_tid;
    logic [TDEST_WIDTH-1:0]         m_tdest;
    logic                           grant_valid;
    logic [REQ_IDX_WIDTH-1:0]       grant_idx;
    logic                           err_overlen;
    logic                           err_clear;

    noc_inject_arbiter #(
        .NUM_REQ(NUM_REQ), .TDATA_WIDTH(TDATA_WIDTH), .TID_WIDTH(TID_WIDTH),
        .TDEST_WIDTH(TDEST_WIDTH), .MAX_PKT_BEATS(MAX_PKT_BEATS), .REQ_IDX_WIDTH(REQ_IDX_WIDTH)
    ) dut (
        .clk_noc(clk_noc), .rst_n(rst_n),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .s_tid(s_tid), .s_tdest(s_tdest),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .m_tid(m_tid), .m_tdest(m_tdest),
        .grant_valid(grant_valid), .grant_idx(grant_idx),
        .err_overlen(err_overlen), .err_clear(err_clear)
    );

    always #5 clk_noc = ~clk_noc;

    int    err_count = 0;
    int    check_count = 0;
    beat_t src_q[NUM_REQ][$];
    logic  src_en[NUM_REQ];
    int    gap_pct = 0;
    int    gnt_log[$];
    logic  prev_gv = 1'b0;

    // Reference model: owner/pointer bookkeeping plus a queue standing in for the buffer.
    logic  mdl_locked;
    int    mdl_owner;
    int    mdl_rr;
    int    mdl_cnt;
    logic  mdl_err;
    beat_t exp_q[$];

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_count++;
        if (got !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mdl_locked = 1'b0;
        mdl_owner  = 0;
        mdl_rr     = NUM_REQ - 1;
        mdl_cnt    = 0;
        mdl_err    = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_edge();
        logic  do_pop, do_push, err_set, found;
        beat_t b;
        do_pop  = (exp_q.size() > 0) && m_tready;
        do_push = 1'b0;
        err_set = 1'b0;
        b       = '0;
        if (mdl_locked) begin
            if (s_tvalid[mdl_owner] && exp_q.size() < 2) begin
                do_push = 1'b1;
                b = src_q[mdl_owner].pop_front();
                if (!b.last && mdl_cnt == MAX_PKT_BEATS - 1) begin
                    b.last  = 1'b1;
                    err_set = 1'b1;
                end
                mdl_cnt++;
                if (b.last) mdl_locked = 1'b0;
            end
        end else begin
            found = 1'b0;
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (!found && s_tvalid[(mdl_rr + k) % NUM_REQ]) begin
                    found     = 1'b1;
                    mdl_owner = (mdl_rr + k) % NUM_REQ;
                end
            end
            if (found) begin
                mdl_locked = 1'b1;
                mdl_rr     = mdl_owner;
                mdl_cnt    = 0;
            end
        end
        if (do_pop)  void'(exp_q.pop_front());
        if (do_push) exp_q.push_back(b);
        if (err_set)        mdl_err = 1'b1;
        else if (err_clear) mdl_err = 1'b0;
    endtask

    task automatic applyStimulus();
        logic [NUM_REQ-1:0]             v, l;
        logic [NUM_REQ*TDATA_WIDTH-1:0] d;
        logic [NUM_REQ*TID_WIDTH-1:0]   t;
        logic [NUM_REQ*TDEST_WIDTH-1:0] de;
        v = '0; l = '0; d = '0; t = '0; de = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_q[i].size() > 0) begin
                v[i] = src_en[i] && ($urandom_range(0, 99) >= gap_pct);
                l[i] = src_q[i][0].last;
                d[i*TDATA_WIDTH +: TDATA_WIDTH] = src_q[i][0].data;
                t[i*TID_WIDTH +: TID_WIDTH]     = src_q[i][0].tid;
                de[i*TDEST_WIDTH +: TDEST_WIDTH] = src_q[i][0].tdest;
            end
        end
        s_tvalid = v; s_tlast = l; s_tdata = d; s_tid = t; s_tdest = de;
    endtask

    task automatic check_all();
        logic [NUM_REQ-1:0] exp_rdy;
        exp_rdy = '0;
        if (mdl_locked && exp_q.size() < 2) exp_rdy[mdl_owner] = 1'b1;
        checkOutput("s_tready", 64'(s_tready), 64'(exp_rdy));
        checkOutput("m_tvalid", 64'(m_tvalid), 64'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            checkOutput("m_tdata", 64'(m_tdata), 64'(exp_q[0].data));
            checkOutput("m_tlast", 64'(m_tlast), 64'(exp_q[0].last));
            checkOutput("m_tid",   64'(m_tid),   64'(exp_q[0].tid));
            checkOutput("m_tdest", 64'(m_tdest), 64'(exp_q[0].tdest));
        end
        checkOutput("grant_valid", 64'(grant_valid), 64'(mdl_locked));
        checkOutput("grant_idx",   64'(grant_idx),   64'(mdl_owner));
        checkOutput("err_overlen", 64'(err_overlen), 64'(mdl_err));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_noc);
            if (rst_n) model_edge();
            @(negedge clk_noc);
            check_all();
            if (grant_valid && !prev_gv) gnt_log.push_back(int'(grant_idx));
            prev_gv = grant_valid;
            applyStimulus();
        end
    endtask

    task automatic add_packet(input int req, input int len, input logic [TDATA_WIDTH-1:0] base,
                              input logic [TID_WIDTH-1:0] tid, input logic [TDEST_WIDTH-1:0] tdest);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data  = base + TDATA_WIDTH'(k);
            b.last  = (k == len - 1);
            b.tid   = tid;
            b.tdest = tdest;
            src_q[req].push_back(b);
        end
    endtask

    function automatic logic busy();
        logic any;
        any = mdl_locked || (exp_q.size() > 0);
        for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() > 0) any = 1'b1;
        return any;
    endfunction

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (busy() && n < limit) begin
            step(1);
            n++;
        end
        if (busy()) checkOutput("drainTimeout", 64'(1), 64'(0));
    endtask

    task automatic do_reset();
        @(negedge clk_noc);
        rst_n = 1'b0;
        #1;
        checkOutput("rstMTvalid", 64'(m_tvalid), 64'(0));
        checkOutput("rstSTready", 64'(s_tready), 64'(0));
        checkOutput("rstGrantValid", 64'(grant_valid), 64'(0));
        model_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            src_q[i].delete();
            src_en[i] = 1'b1;
        end
        prev_gv = 1'b0;
        applyStimulus();
        repeat (2) @(negedge clk_noc);
        checkOutput("rstMTdata", 64'(m_tdata), 64'(0));
        checkOutput("rstMTlast", 64'(m_tlast), 64'(0));
        checkOutput("rstMTid",   64'(m_tid),   64'(0));
        checkOutput("rstMTdest", 64'(m_tdest), 64'(0));
        checkOutput("rstGrantIdx", 64'(grant_idx), 64'(0));
        checkOutput("rstErr", 64'(err_overlen), 64'(0));
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_order[5];
        logic [63:0] first_gnt;
        rst_n = 1'b0; m_tready = 1'b0; err_clear = 1'b0;
        s_tvalid = '0; s_tdata = '0; s_tlast = '0; s_tid = '0; s_tdest = '0;
        for (int i = 0; i < NUM_REQ; i++) src_en[i] = 1'b1;
        model_reset();

        $display("[TB] single 3-beat packet from requester 0");
        do_reset();
        m_tready = 1'b1;
        add_packet(0, 3, 32'hA0, 2'd1, 4'd5);
        applyStimulus();
        drain(50);

        $display("[TB] all requesters busy, round-robin order");
        do_reset();
        m_tready = 1'b1;
        gnt_log.delete();
        add_packet(0, 2, 32'h100, 2'd0, 4'd0);
        add_packet(1, 2, 32'h110, 2'd1, 4'd1);
        add_packet(2, 2, 32'h120, 2'd2, 4'd2);
        add_packet(3, 2, 32'h130, 2'd3, 4'd3);
        add_packet(0, 2, 32'h140, 2'd0, 4'd4);
        applyStimulus();
        drain(100);
        exp_order = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++)
            checkOutput("grantOrder", (k < gnt_log.size()) ? 64'(gnt_log[k]) : 64'hDEAD,
                        64'(exp_order[k]));

        $display("[TB] back-pressure on requester 2");
        add_packet(2, 8, 32'h200, 2'd2, 4'd9);
        applyStimulus();
        step(3);
        m_tready = 1'b0;
        step(5);
        checkOutput("stallReady", 64'(s_tready[2]), 64'(0));
        m_tready = 1'b1;
        drain(100);

        $display("[TB] over-length packet from requester 1");
        add_packet(1, 20, 32'h300, 2'd1, 4'd7);
        applyStimulus();
        drain(200);
        checkOutput("errSticky", 64'(err_overlen), 64'(1));
        err_clear = 1'b1;
        step(1);
        err_clear = 1'b0;
        checkOutput("errCleared", 64'(err_overlen), 64'(0));

        $display("[TB] reset mid-packet");
        add_packet(2, 8, 32'h400, 2'd0, 4'd1);
        m_tready = 1'b0;
        applyStimulus();
        step(6);
        do_reset();
        gnt_log.delete();
        m_tready = 1'b1;
        add_packet(3, 2, 32'h530, 2'd3, 4'd3);
        add_packet(0, 2, 32'h500, 2'd0, 4'd0);
        applyStimulus();
        drain(50);
        first_gnt = (gnt_log.size() > 0) ? 64'(gnt_log[0]) : 64'hDEAD;
        checkOutput("firstGrantAfterReset", first_gnt, 64'(0));

        $display("[TB] requester 3 pauses mid-packet");
        src_en[0] = 1'b0;
        add_packet(3, 6, 32'h630, 2'd1, 4'd2);
        add_packet(0, 3, 32'h600, 2'd2, 4'd6);
        applyStimulus();
        step(3);
        src_en[0] = 1'b1;
        src_en[3] = 1'b0;
        applyStimulus();
        step(4);
        checkOutput("holdGrant", 64'(grant_idx), 64'(3));
        checkOutput("req0Blocked", 64'(s_tready[0]), 64'(0));
        src_en[3] = 1'b1;
        applyStimulus();
        drain(100);

        $display("[TB] randomized traffic");
        gap_pct = 20;
        for (int c = 0; c < 2000; c++) begin
            m_tready  = ($urandom_range(0, 3) != 0);
            err_clear = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < NUM_REQ; i++)
                if (src_q[i].size() == 0 && $urandom_range(0, 7) == 0)
                    add_packet(i, int'($urandom_range(1, 22)), $urandom,
                               TID_WIDTH'($urandom), TDEST_WIDTH'($urandom));
            step(1);
        end
        gap_pct   = 0;
        m_tready  = 1'b1;
        err_clear = 1'b0;
        drain(500);

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule

// File: doc/noc_inject_arbiter.md
Name: noc_inject_arbiter

Overview:
- Shares the router's single AXI-stream injection port among NUM_REQ local requesters.
- Arbitration is packet-atomic round-robin: a grant is held from the first beat to the tlast beat.
- Includes a 2-entry output skid buffer so a locked packet streams at full throughput.
- Enforces a maximum packet length and force-terminates runaway packets so one requester cannot hold the port indefinitely.
- Sits between user logic and the axis_in_* injection interface of the router wrapper, on the NoC clock.

Parameters:
NUM_REQ, 4, number of requesting AXI-stream sources (>=2)
TDATA_WIDTH, 32, data width of every stream
TID_WIDTH, 2, tid width, passed through unchanged
TDEST_WIDTH, 4, tdest width, passed through unchanged
MAX_PKT_BEATS, 16, longest legal packet in beats (>=1)
REQ_IDX_WIDTH, $clog2(NUM_REQ), width of grant index

Ports:
clk_noc  in  1  single clock; all logic on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
s_tvalid  in  NUM_REQ  per-requester valid
s_tready  out  NUM_REQ  per-requester ready
s_tdata  in  NUM_REQ*TDATA_WIDTH  per-requester data, requester i at slice i
s_tlast  in  NUM_REQ  per-requester end of packet
s_tid  in  NUM_REQ*TID_WIDTH  per-requester tid
s_tdest  in  NUM_REQ*TDEST_WIDTH  per-requester tdest
m_tvalid  out  1  to router axis_in_tvalid
m_tready  in  1  from router axis_in_tready
m_tdata  out  TDATA_WIDTH  to router
m_tlast  out  1  to router
m_tid  out  TID_WIDTH  to router
m_tdest  out  TDEST_WIDTH  to router
grant_valid  out  1  high while in LOCKED
grant_idx  out  REQ_IDX_WIDTH  currently/last granted requester
err_overlen  out  1  sticky; set on a forced packet termination
err_clear  in  1  synchronous clear of err_overlen

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; rr_ptr=NUM_REQ-1, so requester 0 has top priority after reset.
  - grant_idx=0, grant_valid=0, beat_cnt=0, err_overlen=0.
  - Skid buffer empty: m_tvalid=0. s_tready=0. m_tdata/tlast/tid/tdest=0.
  - A reset mid-packet discards buffered beats; no partial packet is emitted after reset.
- IDLE state:
  - s_tready=0.
  - If any s_tvalid: winner = first i with s_tvalid[i], searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - Register grant_idx=winner, rr_ptr=winner, beat_cnt=0; next state LOCKED.
  - No request: stay IDLE.
- LOCKED state:
  - grant_valid=1.
  - s_tready[grant_idx] = skid buffer not full; all other s_tready=0.
  - Accepted beat = s_tvalid[g] & s_tready[g]; it is written to the skid buffer with tdata/tid/tdest unchanged.
  - beat_cnt increments per accepted beat.
  - Accepted beat with s_tlast=1: buffered tlast=1; next state IDLE.
  - Accepted beat without s_tlast while beat_cnt==MAX_PKT_BEATS-1:
    - buffered tlast forced to 1; err_overlen<=1; next state IDLE.
    - The remainder of that source's stream re-arbitrates as a new packet.
  - s_tvalid dropping mid-packet: grant is held; no other requester is served.
- Timing:
  - Latency: request seen in IDLE at cycle T -> LOCKED at T+1 -> first beat accepted at T+1 -> m_tvalid=1 at T+2.
  - One IDLE bubble cycle between consecutive packets.
  - Within a packet: 1 beat/cycle sustained while m_tready=1.
- Skid buffer:
  - 2 entries; m_* are driven directly from the head-entry registers.
  - "Full" means 2 entries occupied.
  - Simultaneous push and pop keeps the count unchanged.
  - m_tready=0 with the buffer full: s_tready=0 next cycle, no data lost.
  - Output payload is stable while m_tvalid=1 and m_tready=0.
- Mid-packet IDLE exit: the grant releases on acceptance of the last beat, independent of drain. Buffered beats still drain in order while the next arbitration proceeds.
- err_clear: clears err_overlen at the next edge. If it coincides with a new overlength event, set wins.
- grant_idx holds its value in IDLE until the next arbitration.

Test Plan:
- Reset, then req0 sends a 3-beat packet (data 0xA0..0xA2, tid=1, tdest=5), m_tready=1 -> m_tvalid first high 2 cycles after s_tvalid; 3 consecutive beats; tlast on 0xA2 only; tid/tdest unchanged.
- All 4 requesters continuously valid with 2-beat packets -> grant order 0,1,2,3,0; exactly one IDLE bubble between packets; no interleaving of beats from different requesters.
- req2 mid-packet, m_tready low for 5 cycles -> s_tready[2] falls after 2 beats buffered; no beat lost or duplicated; order preserved on resume.
- req1 sends 20 beats without tlast (MAX_PKT_BEATS=16) -> beat 16 emitted with tlast=1; err_overlen=1; beats 17-20 emitted as a new packet ending at req1's tlast; err_clear returns err_overlen to 0.
- rst_n asserted mid-packet with 2 beats buffered -> m_tvalid=0 and s_tready=0 immediately. After release, the first grant goes to requester 0 when requesters 0 and 3 are both valid.
- req3 s_tvalid drops mid-packet while req0 is valid -> grant stays on 3; req0's s_tready stays 0 until req3's tlast is accepted.
